// File: rtl/cfg_access_master_pkg.sv
// Shared types for the register-bus access master: command opcodes and FSM states.
package cfg_access_master_pkg;

    typedef enum logic [1:0] {
        OP_WRITE   = 2'd0,
        OP_READ    = 2'd1,
        OP_POLL    = 2'd2,
        OP_ILLEGAL = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RSP   = 2'd3
    } state_e;

endpackage

// File: rtl/cfg_access_master.sv
// Register-bus initiator: WRITE/READ/POLL commands in, single-word bus accesses, responses out.
// Define CFG_ACCESS_MASTER_POSTED_WRITE_EN to make writes posted (no response).
module cfg_access_master
    import cfg_access_master_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned POLL_CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_data,
    input  logic [DATA_WIDTH/8-1:0]   cmd_be,
    input  logic [DATA_WIDTH-1:0]     cmd_mask,
    input  logic [POLL_CNT_W-1:0]     poll_limit,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_data,
    output logic                      rsp_err,
    output logic                      en,
    output logic [ADDR_WIDTH-1:0]     addr,
    output logic                      we,
    output logic [DATA_WIDTH/8-1:0]   be,
    output logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH-1:0]     rdata,
    output logic                      busy
);

    localparam int unsigned BeW = DATA_WIDTH / 8;

    state_e                  state_q, state_d;
    cmd_op_e                 op_q, op_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [BeW-1:0]          be_q, be_d;
    logic [DATA_WIDTH-1:0]   mask_q, mask_d;
    logic [POLL_CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    en_q, en_d;
    logic                    we_q, we_d;
    logic [BeW-1:0]          bus_be_q, bus_be_d;

    logic                    capture;
    logic                    match;
    logic                    timeout;
    logic [POLL_CNT_W-1:0]   cnt_inc;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        data_d      = data_q;
        be_d        = be_q;
        mask_d      = mask_q;
        cnt_d       = cnt_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;

        // Read data is valid in ISSUE for an async responder, otherwise one cycle later in WAIT.
        capture = (op_q != OP_WRITE) &&
                  ((state_q == WAIT) || ((state_q == ISSUE) && (READ_LATENCY == 0)));
        match   = ((rdata ^ data_q) & mask_q) == '0;
        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + POLL_CNT_W'(1);
        timeout = (poll_limit != '0) && (cnt_inc == poll_limit);

        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d   = cmd_op_e'(cmd_op);
                    addr_d = cmd_addr;
                    data_d = cmd_data;
                    be_d   = cmd_be;
                    mask_d = cmd_mask;
                    cnt_d  = '0;
                    if (cmd_op_e'(cmd_op) == OP_ILLEGAL) begin
                        state_d    = RSP;
                        rsp_err_d  = 1'b1;
                        rsp_data_d = '0;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (op_q == OP_WRITE) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
`ifdef CFG_ACCESS_MASTER_POSTED_WRITE_EN
                    state_d    = IDLE;
`else
                    state_d    = RSP;
`endif
                end else if (READ_LATENCY != 0) begin
                    state_d = WAIT;
                end
            end
            WAIT: ;
            RSP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            rsp_data_d = rdata;
            rsp_err_d  = 1'b0;
            if ((op_q == OP_READ) || match) begin
                state_d = RSP;
            end else begin
                cnt_d = cnt_inc;
                if (timeout) begin
                    state_d   = RSP;
                    rsp_err_d = 1'b1;
                end else begin
                    state_d = ISSUE;
                end
            end
        end

        // Registered outputs are decoded from the next state so they line up with it.
        cmd_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RSP);
        en_d        = (state_d == ISSUE);
        we_d        = en_d && (op_d == OP_WRITE);
        bus_be_d    = we_d ? be_d : '0;
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q     <= IDLE;
            op_q        <= OP_WRITE;
            addr_q      <= '0;
            data_q      <= '0;
            be_q        <= '0;
            mask_q      <= '0;
            cnt_q       <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b0;
            en_q        <= 1'b0;
            we_q        <= 1'b0;
            bus_be_q    <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            be_q        <= be_d;
            mask_q      <= mask_d;
            cnt_q       <= cnt_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= rsp_valid_d;
            cmd_ready_q <= cmd_ready_d;
            en_q        <= en_d;
            we_q        <= we_d;
            bus_be_q    <= bus_be_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign en        = en_q;
    assign addr      = addr_q;
    assign we        = we_q;
    assign be        = bus_be_q;
    assign wdata     = data_q;
    assign busy      = (state_q != IDLE);

endmodule
